// File: rtl/tm_entry_sequencer_if.sv
// Button/data inputs and strobe/status outputs between the TM entry sequencer and its datapath/UI.
interface tm_entry_sequencer_if #(
    parameter int DATA_W     = 6,
    parameter int TAPE_DEPTH = 64
);
    localparam int ADDR_W = $clog2(TAPE_DEPTH);

    logic                next;
    logic                done;
    logic [DATA_W-1:0]   input_data;
    logic                halted;
    logic                tbl_we;
    logic [DATA_W:0]     tbl_addr;
    logic [DATA_W+2:0]   tbl_wdata;
    logic                tape_we;
    logic [ADDR_W-1:0]   tape_addr;
    logic                tape_wdata;
    logic                dp_clear;
    logic                step_en;
    logic [1:0]          phase;
    logic [1:0]          field_idx;
    logic                compute_done;

    modport master (
        input  next, done, input_data, halted,
        output tbl_we, tbl_addr, tbl_wdata, tape_we, tape_addr, tape_wdata,
               dp_clear, step_en, phase, field_idx, compute_done
    );

    modport slave (
        output next, done, input_data, halted,
        input  tbl_we, tbl_addr, tbl_wdata, tape_we, tape_addr, tape_wdata,
               dp_clear, step_en, phase, field_idx, compute_done
    );
endinterface

// File: rtl/tm_entry_sequencer.sv
// Turing machine front-end: table/tape entry from Next/Done buttons, then stepped execution.
// Optional TM_AUTORUN_EN: in RUN, Next toggles free-running stepping until the datapath halts.
//
// state   | meaning
// PH_PROG | entering transition table, 3 fields per entry
// PH_TAPE | entering tape cells
// PH_RUN  | executing, one step per Next (or free-run)
// PH_HALT | datapath reached halt state, compute_done high
module tm_entry_sequencer #(
    parameter int DATA_W     = 6,
    parameter int TAPE_DEPTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    tm_entry_sequencer_if.master   bus
);
    localparam int ADDR_W = $clog2(TAPE_DEPTH);
    localparam int ENT_W  = DATA_W + 1;

    typedef enum logic [1:0] {
        PH_PROG = 2'd0,
        PH_TAPE = 2'd1,
        PH_RUN  = 2'd2,
        PH_HALT = 2'd3
    } phase_t;

    phase_t              state;
    logic                next_q;
    logic                done_q;
    logic                nx_p;
    logic                dn_p;
    logic [ENT_W-1:0]    entry_cnt;
    logic                tbl_full;
    logic [DATA_W-1:0]   ns_r;
    logic                ws_r;
    logic [1:0]          field_r;
    logic [ADDR_W-1:0]   tape_ptr;
    logic                tape_full;

    logic                tbl_we_r;
    logic [DATA_W:0]     tbl_addr_r;
    logic [DATA_W+2:0]   tbl_wdata_r;
    logic                tape_we_r;
    logic [ADDR_W-1:0]   tape_addr_r;
    logic                tape_wdata_r;
    logic                dp_clear_r;
    logic                step_en_r;
    logic                compute_done_r;
`ifdef TM_AUTORUN_EN
    logic                free_run;
`endif

    // Done has priority: a simultaneous Next edge is discarded.
    assign dn_p = bus.done & ~done_q;
    assign nx_p = bus.next & ~next_q & ~dn_p;

    always_ff @(posedge clock) begin
        // Edge registers track the buttons during reset so a held button does not fire on release.
        next_q <= bus.next;
        done_q <= bus.done;
        if (!reset) begin
            state          <= PH_PROG;
            entry_cnt      <= '0;
            tbl_full       <= 1'b0;
            ns_r           <= '0;
            ws_r           <= 1'b0;
            field_r        <= 2'd0;
            tape_ptr       <= '0;
            tape_full      <= 1'b0;
            tbl_we_r       <= 1'b0;
            tbl_addr_r     <= '0;
            tbl_wdata_r    <= '0;
            tape_we_r      <= 1'b0;
            tape_addr_r    <= '0;
            tape_wdata_r   <= 1'b0;
            dp_clear_r     <= 1'b0;
            step_en_r      <= 1'b0;
            compute_done_r <= 1'b0;
`ifdef TM_AUTORUN_EN
            free_run       <= 1'b0;
`endif
        end else begin
            tbl_we_r   <= 1'b0;
            tape_we_r  <= 1'b0;
            dp_clear_r <= 1'b0;
            step_en_r  <= 1'b0;
            unique case (state)
                PH_PROG: begin
                    if (dn_p) begin
                        state   <= PH_TAPE;
                        field_r <= 2'd0;
                    end else if (nx_p && !tbl_full) begin
                        case (field_r)
                            2'd0: begin
                                ns_r    <= bus.input_data;
                                field_r <= 2'd1;
                            end
                            2'd1: begin
                                ws_r    <= bus.input_data[0];
                                field_r <= 2'd2;
                            end
                            default: begin
                                tbl_we_r    <= 1'b1;
                                tbl_addr_r  <= entry_cnt;
                                tbl_wdata_r <= {ns_r, ws_r, bus.input_data[1:0]};
                                field_r     <= 2'd0;
                                if (&entry_cnt) tbl_full <= 1'b1;
                                else            entry_cnt <= entry_cnt + ENT_W'(1);
                            end
                        endcase
                    end
                end
                PH_TAPE: begin
                    if (dn_p) begin
                        state       <= PH_RUN;
                        dp_clear_r  <= 1'b1;
                        tape_ptr    <= '0;
                        tape_addr_r <= '0;
                        tape_full   <= 1'b0;
`ifdef TM_AUTORUN_EN
                        free_run    <= 1'b0;
`endif
                    end else if (nx_p && !tape_full) begin
                        tape_we_r    <= 1'b1;
                        tape_addr_r  <= tape_ptr;
                        tape_wdata_r <= bus.input_data[0];
                        if (tape_ptr == ADDR_W'(TAPE_DEPTH - 1)) tape_full <= 1'b1;
                        else                                     tape_ptr  <= tape_ptr + ADDR_W'(1);
                    end
                end
                PH_RUN: begin
                    if (bus.halted) begin
                        state          <= PH_HALT;
                        compute_done_r <= 1'b1;
`ifdef TM_AUTORUN_EN
                        free_run       <= 1'b0;
`endif
                    end else begin
`ifdef TM_AUTORUN_EN
                        free_run  <= free_run ^ nx_p;
                        step_en_r <= free_run ^ nx_p;
`else
                        step_en_r <= nx_p;
`endif
                    end
                end
                PH_HALT: begin
                    if (dn_p) begin
                        state          <= PH_PROG;
                        entry_cnt      <= '0;
                        tbl_full       <= 1'b0;
                        field_r        <= 2'd0;
                        tape_ptr       <= '0;
                        tape_full      <= 1'b0;
                        tbl_addr_r     <= '0;
                        tape_addr_r    <= '0;
                        compute_done_r <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.tbl_we       = tbl_we_r;
    assign bus.tbl_addr     = tbl_addr_r;
    assign bus.tbl_wdata    = tbl_wdata_r;
    assign bus.tape_we      = tape_we_r;
    assign bus.tape_addr    = tape_addr_r;
    assign bus.tape_wdata   = tape_wdata_r;
    assign bus.dp_clear     = dp_clear_r;
    assign bus.step_en      = step_en_r;
    assign bus.phase        = state;
    assign bus.field_idx    = field_r;
    assign bus.compute_done = compute_done_r;
endmodule
